// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS controller: FSM states, opcode/funct codes, ALU codes, strobe bundle.
// Build option MC_ILLEGAL_TRAP_EN adds the sticky TRAP state.
package mc_pkg;

  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int ALUC_W  = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_NOT = 3'b100;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_ILLEGAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       trap;
  } ctl_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and status in, ALU code and strobes out.
// master = controller side, slave = datapath side.
interface mc_if;
  import mc_pkg::*;

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               mem_ready;
  logic [ALUC_W-1:0]  aluControl;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic [1:0]         pc_src;
  logic               pc_write;
  logic               trap;

  modport master (
    input  op, funct, zero, mem_ready,
    output aluControl, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_write, trap
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  aluControl, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_write, trap
  );

endinterface

// File: rtl/alu_dec.sv
// alu_dec: maps ALU operation class plus funct to the 3-bit ALU code.
// Latency: combinational. Backpressure: none.
module alu_dec
  import mc_pkg::*;
(
  input  aluop_t             aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_SUB:   alu_control = ALU_SUB;
          F_AND:   alu_control = ALU_AND;
          F_OR:    alu_control = ALU_OR;
          F_NOR:   alu_control = ALU_NOT;
          F_SLT:   alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM + ALU decode; MC_ILLEGAL_TRAP_EN makes illegal opcodes sticky-trap.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles, plus one cycle per mem_ready=0 in FETCH/MEMRD/MEMWR.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mc_if.master bus
);

  state_t            state;
  state_t            nxt;
  ctl_t              ctl;
  ctl_t              ctl_o;
  aluop_t            aluop;
  logic [ALUC_W-1:0] alu_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nxt;
  end

  always_comb begin
    nxt   = state;
    ctl   = '0;
    aluop = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.src_b    = SRCB_FOUR;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCSRC_ALU;
          nxt          = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.src_b = SRCB_IMM4;
        case (bus.op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ctl.src_a = 1'b1;
        ctl.src_b = SRCB_IMM;
        nxt       = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (bus.mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        nxt            = S_FETCH;
      end
      // Moore strobe: stays high every stall cycle until the memory accepts.
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (bus.mem_ready) nxt = S_FETCH;
      end
      S_EXEC: begin
        ctl.src_a = 1'b1;
        ctl.src_b = SRCB_REG;
        aluop     = ALUOP_FUNCT;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        nxt           = S_FETCH;
      end
      S_BRANCH: begin
        ctl.src_a    = 1'b1;
        ctl.src_b    = SRCB_REG;
        ctl.pc_src   = PCSRC_OUT;
        ctl.pc_write = bus.zero;
        aluop        = ALUOP_SUB;
        nxt          = S_FETCH;
      end
      S_ADDIEX: begin
        ctl.src_a = 1'b1;
        ctl.src_b = SRCB_IMM;
        nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
        nxt           = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_src   = PCSRC_JUMP;
        ctl.pc_write = 1'b1;
        nxt          = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        nxt = S_TRAP;
`else
        nxt = S_FETCH;
`endif
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: ctl.trap = 1'b1;
`endif
      default: nxt = S_FETCH;
    endcase
  end

  alu_dec u_alu_dec (
    .aluop       (aluop),
    .funct       (bus.funct),
    .alu_control (alu_c)
  );

  // Gating with rst_n drops every strobe the instant reset asserts, not at the next edge.
  assign ctl_o          = rst_n ? ctl : '0;
  assign bus.aluControl = rst_n ? alu_c : ALU_ADD;
  assign bus.alu_src_a  = ctl_o.src_a;
  assign bus.alu_src_b  = ctl_o.src_b;
  assign bus.iord       = ctl_o.iord;
  assign bus.mem_read   = ctl_o.mem_read;
  assign bus.mem_write  = ctl_o.mem_write;
  assign bus.ir_write   = ctl_o.ir_write;
  assign bus.reg_write  = ctl_o.reg_write;
  assign bus.reg_dst    = ctl_o.reg_dst;
  assign bus.mem_to_reg = ctl_o.mem_to_reg;
  assign bus.pc_src     = ctl_o.pc_src;
  assign bus.pc_write   = ctl_o.pc_write;
  assign bus.trap       = ctl_o.trap;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level vector table, reset/stall/illegal sequences, and
// randomized instruction streams checked cycle by cycle against an instruction-expansion model.
module tb_mc_controller;

  typedef struct packed {
    logic [2:0] alu;
    logic       a;
    logic [1:0] b;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rgw;
    logic       rdst;
    logic       m2r;
    logic [1:0] pcs;
    logic       pcw;
    logic       trap;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         len;
    logic [2:0] alu3;
    logic       pcw_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  obs_t exq[$];
  bit   rdq[$];

  always #5 clk = ~clk;

  mc_if bus ();

  mc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.alu  = bus.aluControl;
    o.a    = bus.alu_src_a;
    o.b    = bus.alu_src_b;
    o.iord = bus.iord;
    o.mrd  = bus.mem_read;
    o.mwr  = bus.mem_write;
    o.irw  = bus.ir_write;
    o.rgw  = bus.reg_write;
    o.rdst = bus.reg_dst;
    o.m2r  = bus.mem_to_reg;
    o.pcs  = bus.pc_src;
    o.pcw  = bus.pc_write;
    o.trap = bus.trap;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // ALU code the instruction set assigns to each R-type funct.
  function automatic logic [2:0] exp_alu(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b001;
      6'h24:   return 3'b010;
      6'h25:   return 3'b011;
      6'h27:   return 3'b100;
      6'h2A:   return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t fetch_exp(input bit rdy);
    obs_t e = '0;
    e.mrd = 1'b1;
    e.b   = 2'b01;
    e.irw = rdy;
    e.pcw = rdy;
    return e;
  endfunction

  task automatic push(input obs_t e, input bit r);
    exq.push_back(e);
    rdq.push_back(r);
  endtask

  // Expand one instruction into its expected per-cycle strobes and the mem_ready to drive each cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input int wf, input int wm);
    obs_t e;
    exq.delete();
    rdq.delete();
    for (int i = 0; i < wf; i++) push(fetch_exp(1'b0), 1'b0);
    push(fetch_exp(1'b1), 1'b1);
    e = '0; e.b = 2'b11;
    push(e, 1'($urandom_range(0, 1)));
    case (op)
      6'h23, 6'h2B: begin
        e = '0; e.a = 1'b1; e.b = 2'b10;
        push(e, 1'($urandom_range(0, 1)));
        e = '0; e.iord = 1'b1;
        if (op == 6'h23) e.mrd = 1'b1; else e.mwr = 1'b1;
        for (int i = 0; i < wm; i++) push(e, 1'b0);
        push(e, 1'b1);
        if (op == 6'h23) begin
          e = '0; e.rgw = 1'b1; e.m2r = 1'b1;
          push(e, 1'($urandom_range(0, 1)));
        end
      end
      6'h00: begin
        e = '0; e.a = 1'b1; e.alu = exp_alu(funct);
        push(e, 1'($urandom_range(0, 1)));
        e = '0; e.rgw = 1'b1; e.rdst = 1'b1;
        push(e, 1'($urandom_range(0, 1)));
      end
      6'h04: begin
        e = '0; e.a = 1'b1; e.alu = 3'b001; e.pcs = 2'b01; e.pcw = zero;
        push(e, 1'($urandom_range(0, 1)));
      end
      6'h08: begin
        e = '0; e.a = 1'b1; e.b = 2'b10;
        push(e, 1'($urandom_range(0, 1)));
        e = '0; e.rgw = 1'b1;
        push(e, 1'($urandom_range(0, 1)));
      end
      6'h02: begin
        e = '0; e.pcs = 2'b10; e.pcw = 1'b1;
        push(e, 1'($urandom_range(0, 1)));
      end
      default: push('0, 1'($urandom_range(0, 1)));
    endcase
  endtask

  // Entered in the low phase of a FETCH cycle; leaves in the low phase of the following FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] funct,
                           input logic zero, input int wf, input int wm);
    build(op, funct, zero, wf, wm);
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = zero;
    for (int i = 0; i < exq.size(); i++) begin
      bus.mem_ready = rdq[i];
      #1;
      check_obs($sformatf("%s op=%h f=%h c%0d", tag, op, funct, i + 1), sample(), exq[i]);
      @(negedge clk);
    end
  endtask

  // Runs one instruction with memory always ready; reports cycles until FETCH shows up again.
  task automatic measure(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                         output int len, output logic [2:0] alu3, output logic pcw_last);
    obs_t o;
    obs_t prev = '0;
    len = 0;
    alu3 = 3'bxxx;
    pcw_last = 1'bx;
    bus.op = op;
    bus.funct = funct;
    bus.zero = zero;
    bus.mem_ready = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      #1;
      o = sample();
      if (n > 1 && o.mrd && !o.iord && o.b == 2'b01) begin
        len = n - 1;
        pcw_last = prev.pcw;
        return;
      end
      if (n == 3) alu3 = o.alu;
      prev = o;
      @(negedge clk);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int         len;
    logic [2:0] alu3;
    logic       pcwl;
    obs_t       e;

    tbl[0] = '{6'h23, 6'h00, 1'b0, 5, 3'b000, 1'b0};
    tbl[1] = '{6'h2B, 6'h00, 1'b0, 4, 3'b000, 1'b0};
    tbl[2] = '{6'h00, 6'h22, 1'b0, 4, 3'b001, 1'b0};
    tbl[3] = '{6'h00, 6'h2A, 1'b0, 4, 3'b101, 1'b0};
    tbl[4] = '{6'h00, 6'h25, 1'b0, 4, 3'b011, 1'b0};
    tbl[5] = '{6'h04, 6'h00, 1'b1, 3, 3'b001, 1'b1};
    tbl[6] = '{6'h04, 6'h00, 1'b0, 3, 3'b001, 1'b0};
    tbl[7] = '{6'h08, 6'h00, 1'b0, 4, 3'b000, 1'b0};
    tbl[8] = '{6'h02, 6'h00, 1'b0, 3, 3'b000, 1'b1};

    rst_n = 1'b0;
    bus.op = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    check_obs("reset_outputs", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    bus.mem_ready = 1'b0;
    #1;
    check_obs("reset_release", sample(), fetch_exp(1'b0));

    foreach (tbl[i]) begin
      measure(tbl[i].op, tbl[i].funct, tbl[i].zero, len, alu3, pcwl);
      check_val($sformatf("len op=%h f=%h", tbl[i].op, tbl[i].funct), len, tbl[i].len);
      check_val($sformatf("alu3 op=%h f=%h", tbl[i].op, tbl[i].funct), int'(alu3), int'(tbl[i].alu3));
      check_val($sformatf("pcw_last op=%h z=%0d", tbl[i].op, tbl[i].zero), int'(pcwl), int'(tbl[i].pcw_last));
    end

    // lw back-to-back with ready, then a 3-cycle fetch stall
    run_instr("lw_seq", 6'h23, 6'h00, 1'b0, 0, 0);
    run_instr("fetch_stall", 6'h02, 6'h00, 1'b0, 3, 0);

    // Reset while sw waits on memory
    bus.op = 6'h2B;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    #1;
    e = '0; e.mwr = 1'b1; e.iord = 1'b1;
    check_obs("memwr_wait", sample(), e);
    #1;
    rst_n = 1'b0;
    #1;
    check_obs("memwr_rst_async", sample(), '0);
    @(posedge clk);
    #1;
    check_obs("memwr_rst_held", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_obs("memwr_rst_fetch", sample(), fetch_exp(1'b0));

`ifdef MC_ILLEGAL_TRAP_EN
    run_instr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0);
    e = '0; e.trap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_obs($sformatf("trap_hold c%0d", i), sample(), e);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`else
    run_instr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0);
    bus.mem_ready = 1'b0;
    #1;
    check_obs("illegal_ret", sample(), fetch_exp(1'b0));
`endif

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
`ifdef MC_ILLEGAL_TRAP_EN
      int sel = $urandom_range(0, 5);
`else
      int sel = $urandom_range(0, 6);
`endif
      case (sel)
        0:       op = 6'h23;
        1:       op = 6'h2B;
        2:       op = 6'h00;
        3:       op = 6'h04;
        4:       op = 6'h08;
        5:       op = 6'h02;
        default: op = 6'h3F;
      endcase
      case ($urandom_range(0, 6))
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        2:       fn = 6'h24;
        3:       fn = 6'h25;
        4:       fn = 6'h27;
        5:       fn = 6'h2A;
        default: fn = 6'($urandom);
      endcase
      run_instr("rnd", op, fn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
